// File: rtl/stream_video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_video_pkg
//  Description : Shared definitions for the elastic video stream buffer:
//                default pixel width, positions of the sideband bits inside
//                a stored beat, and a constant ceil(log2) helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_video_pkg;

    // Default pixel width (RGB888).
    localparam int PIX_WIDTH = 24;

    // A stored beat is {tuser, tlast, tdata}.
    localparam int TUSER_BIT = PIX_WIDTH + 1;
    localparam int TLAST_BIT = PIX_WIDTH;

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : stream_video_pkg
`default_nettype wire

// File: rtl/stream_video_fifo_mon_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_video_fifo_mon_if
//  Description : AXI4-Stream video channel (tdata/tvalid/tready/tuser/tlast).
//                master : drives data, valid and sideband; samples ready.
//                slave  : samples data, valid and sideband; drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_video_fifo_mon_if #(
    parameter int PIX_WIDTH = 24
) ();

    logic [PIX_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tuser;   // start of frame
    logic                 tlast;   // end of line

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface : stream_video_fifo_mon_if
`default_nettype wire

// File: rtl/stream_video_geom_mon.sv
`default_nettype none
// ============================================================================
//  Module      : stream_video_geom_mon
//  Description : Measures line width and frame height of a video stream from
//                its accepted beats and flags structural errors.
//  Ports       : clk, reset (async, active-low)
//                i_beat, i_tuser, i_tlast   - accepted beat and its sideband
//                o_frame_width              - length of first line of frame
//                o_frame_height             - lines in last completed frame
//                o_frame_done               - pulse when height is latched
//                o_line_err                 - pulse on line length mismatch
//                o_sof_err                  - pulse on tuser mid-line
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_video_geom_mon #(
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 i_beat,
    input  wire logic                 i_tuser,
    input  wire logic                 i_tlast,
    output logic      [CNT_WIDTH-1:0] o_frame_width,
    output logic      [CNT_WIDTH-1:0] o_frame_height,
    output logic                      o_frame_done,
    output logic                      o_line_err,
    output logic                      o_sof_err
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
    endfunction

    logic [CNT_WIDTH-1:0] r_col_cnt;
    logic [CNT_WIDTH-1:0] r_row_cnt;
    logic [CNT_WIDTH-1:0] r_frame_width;
    logic [CNT_WIDTH-1:0] r_frame_height;
    logic                 r_sof_seen;
    logic                 r_frame_done;
    logic                 r_line_err;
    logic                 r_sof_err;

    logic [CNT_WIDTH-1:0] w_col_base;
    logic [CNT_WIDTH-1:0] w_row_base;
    logic [CNT_WIDTH-1:0] w_line_len;
    logic [CNT_WIDTH-1:0] w_col_nxt;
    logic [CNT_WIDTH-1:0] w_row_nxt;
    logic [CNT_WIDTH-1:0] w_width_nxt;
    logic [CNT_WIDTH-1:0] w_height_nxt;
    logic                 w_sof_seen_nxt;
    logic                 w_frame_done_nxt;
    logic                 w_line_err_nxt;
    logic                 w_sof_err_nxt;

    always_comb begin
        // A tuser beat restarts both counters before it is itself counted,
        // so it becomes column 0 of the first line of a new frame.
        w_col_base       = i_tuser ? '0 : r_col_cnt;
        w_row_base       = i_tuser ? '0 : r_row_cnt;
        w_line_len       = sat_inc(w_col_base);

        w_col_nxt        = r_col_cnt;
        w_row_nxt        = r_row_cnt;
        w_width_nxt      = r_frame_width;
        w_height_nxt     = r_frame_height;
        w_sof_seen_nxt   = r_sof_seen;
        w_frame_done_nxt = 1'b0;
        w_line_err_nxt   = 1'b0;
        w_sof_err_nxt    = 1'b0;

        if (i_beat) begin
            if (i_tuser) begin
                w_sof_err_nxt  = (r_col_cnt != '0);
                w_sof_seen_nxt = 1'b1;
                // Rows counted before the first tuser do not form a frame.
                if (r_sof_seen && (r_row_cnt != '0)) begin
                    w_height_nxt     = r_row_cnt;
                    w_frame_done_nxt = 1'b1;
                end
            end

            if (i_tlast) begin
                if (w_row_base == '0) begin
                    w_width_nxt = w_line_len;
                end else if (w_line_len != r_frame_width) begin
                    w_line_err_nxt = 1'b1;
                end
                w_row_nxt = sat_inc(w_row_base);
                w_col_nxt = '0;
            end else begin
                w_row_nxt = w_row_base;
                w_col_nxt = sat_inc(w_col_base);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_cnt      <= '0;
            r_row_cnt      <= '0;
            r_frame_width  <= '0;
            r_frame_height <= '0;
            r_sof_seen     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_line_err     <= 1'b0;
            r_sof_err      <= 1'b0;
        end else begin
            r_col_cnt      <= w_col_nxt;
            r_row_cnt      <= w_row_nxt;
            r_frame_width  <= w_width_nxt;
            r_frame_height <= w_height_nxt;
            r_sof_seen     <= w_sof_seen_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_line_err     <= w_line_err_nxt;
            r_sof_err      <= w_sof_err_nxt;
        end
    end

    assign o_frame_width  = r_frame_width;
    assign o_frame_height = r_frame_height;
    assign o_frame_done   = r_frame_done;
    assign o_line_err     = r_line_err;
    assign o_sof_err      = r_sof_err;

endmodule : stream_video_geom_mon
`default_nettype wire

// File: rtl/stream_video_fifo_mon.sv
`default_nettype none
// ============================================================================
//  Module      : stream_video_fifo_mon
//  Description : Elastic first-word-fall-through AXI4-Stream video FIFO with
//                an output-side geometry monitor.
//  Ports       : clk, reset (async, active-low)
//                s_axis_video  - slave stream (from convolution filter)
//                m_axis_video  - master stream (to sink)
//                level         - entries currently stored
//                frame_width   - length of first line of most recent frame
//                frame_height  - line count of last completed frame
//                frame_done    - pulse when frame_height is latched
//                line_err      - pulse when a line length differs
//                sof_err       - pulse when tuser arrives mid-line
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_video_fifo_mon #(
    parameter int PIX_WIDTH = stream_video_pkg::PIX_WIDTH,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                                   clk,
    input  wire logic                                   reset,
    stream_video_fifo_mon_if.slave                      s_axis_video,
    stream_video_fifo_mon_if.master                     m_axis_video,
    output logic [stream_video_pkg::clog2(DEPTH):0]     level,
    output logic [CNT_WIDTH-1:0]                        frame_width,
    output logic [CNT_WIDTH-1:0]                        frame_height,
    output logic                                        frame_done,
    output logic                                        line_err,
    output logic                                        sof_err
);

    import stream_video_pkg::*;

    localparam int c_AW = clog2(DEPTH);
    localparam int c_BW = PIX_WIDTH + 2;
    // Sideband positions are defined relative to the pixel field.
    localparam int c_TUSER_BIT = PIX_WIDTH + (TUSER_BIT - stream_video_pkg::PIX_WIDTH);
    localparam int c_TLAST_BIT = PIX_WIDTH + (TLAST_BIT - stream_video_pkg::PIX_WIDTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

    logic [c_BW-1:0] r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            r_in_ready_en;

    logic            w_full;
    logic            w_empty;
    logic            w_s_ready;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [c_BW-1:0] w_wr_word;
    logic [c_BW-1:0] w_head;

    // Pointers carry one extra lap bit: equal means empty, equal low bits
    // with differing lap bits means full.
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Ready is held low until the first clock after reset release; it
    // depends only on registered state, so a sink stall never reaches the
    // source combinationally.
    assign w_s_ready = r_in_ready_en && !w_full;
    assign w_wr_en   = s_axis_video.tvalid && w_s_ready;
    assign w_rd_en   = !w_empty && m_axis_video.tready;

    always_comb begin
        w_wr_word                  = '0;
        w_wr_word[PIX_WIDTH-1:0]   = s_axis_video.tdata;
        w_wr_word[c_TUSER_BIT]     = s_axis_video.tuser;
        w_wr_word[c_TLAST_BIT]     = s_axis_video.tlast;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_in_ready_en <= 1'b0;
        end else begin
            r_in_ready_en <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is not reset, so the head is masked while empty; this keeps
    // the outputs at zero after reset and never exposes stale entries.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    assign s_axis_video.tready = w_s_ready;
    assign m_axis_video.tvalid = !w_empty;
    assign m_axis_video.tdata  = w_head[PIX_WIDTH-1:0];
    assign m_axis_video.tuser  = w_head[c_TUSER_BIT];
    assign m_axis_video.tlast  = w_head[c_TLAST_BIT];

    assign level = r_wr_ptr - r_rd_ptr;

    stream_video_geom_mon #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_geom_mon (
        .clk            (clk),
        .reset          (reset),
        .i_beat         (w_rd_en),
        .i_tuser        (m_axis_video.tuser),
        .i_tlast        (m_axis_video.tlast),
        .o_frame_width  (frame_width),
        .o_frame_height (frame_height),
        .o_frame_done   (frame_done),
        .o_line_err     (line_err),
        .o_sof_err      (sof_err)
    );

endmodule : stream_video_fifo_mon
`default_nettype wire

// File: tb/tb_stream_video_fifo_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_video_fifo_mon
//  Description : Directed self-checking bench for stream_video_fifo_mon.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_video_fifo_mon;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  level;
    logic [15:0] frame_width;
    logic [15:0] frame_height;
    logic        frame_done;
    logic        line_err;
    logic        sof_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_done = 0;
    int n_line = 0;
    int n_sof  = 0;
    int done_cyc = 0;
    int line_cyc = 0;
    int sof_cyc  = 0;
    int t0 = 0;
    int t_err = 0;
    bit acc;

    stream_video_fifo_mon_if #(.PIX_WIDTH(24)) s_if ();
    stream_video_fifo_mon_if #(.PIX_WIDTH(24)) m_if ();

    stream_video_fifo_mon #(
        .PIX_WIDTH (24),
        .DEPTH     (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_video (s_if),
        .m_axis_video (m_if),
        .level        (level),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .frame_done   (frame_done),
        .line_err     (line_err),
        .sof_err      (sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (line_err)   begin n_line++; line_cyc = cyc; end
        if (sof_err)    begin n_sof++;  sof_cyc  = cyc; end
    endtask

    task automatic clear_pulse_counts();
        n_done = 0;
        n_line = 0;
        n_sof  = 0;
    endtask

    // Presents one beat for one cycle (m_tready left as is).
    task automatic drive_beat(input logic u, input logic l, input int d);
        s_if.tvalid = 1'b1;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tdata  = 24'(d);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens [3];
        reset       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_s_tready", 32'(s_if.tready), 32'(0));
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'(0));
        chk("rst_m_tdata",  32'(m_if.tdata),  32'(0));
        chk("rst_m_tuser",  32'(m_if.tuser),  32'(0));
        chk("rst_m_tlast",  32'(m_if.tlast),  32'(0));
        chk("rst_level",    32'(level),       32'(0));
        chk("rst_width",    32'(frame_width), 32'(0));
        chk("rst_height",   32'(frame_height), 32'(0));
        chk("rst_pulses",   32'({frame_done, line_err, sof_err}), 32'(0));
        #2 reset = 1'b1;
        #2 chk("rel_s_tready_before_edge", 32'(s_if.tready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_s_tready_after_edge", 32'(s_if.tready), 32'(1));

        // ---------------- fill 16 with sink stalled ----------------
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = 24'(i);
            @(negedge clk);
            chk("fill_level",   32'(level),       32'(i - 1));
            chk("fill_s_tready", 32'(s_if.tready), 32'(1));
        end
        @(posedge clk); #1;
        s_if.tdata = 24'(17);
        @(negedge clk);
        chk("full_level",    32'(level),       32'(16));
        chk("full_s_tready", 32'(s_if.tready), 32'(0));
        chk("full_m_tvalid", 32'(m_if.tvalid), 32'(1));
        chk("full_head",     32'(m_if.tdata),  32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_hold_level", 32'(level), 32'(16));
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(m_if.tvalid), 32'(1));
            chk("drain_order", 32'(m_if.tdata),  32'(k));
            if (k == 1) chk("full_read_no_write", 32'(s_if.tready), 32'(0));
            if (k == 2) chk("level_after_read",   32'(level),       32'(15));
            acc = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            if (acc) s_if.tvalid = 1'b0;
        end
        @(negedge clk);
        chk("drained_valid", 32'(m_if.tvalid), 32'(0));
        chk("drained_level", 32'(level),       32'(0));
        @(posedge clk); #1;

        // ---------------- continuous stream ----------------
        for (int i = 0; i < 8; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 24'(100 + i);
            @(negedge clk);
            if (i == 0) begin
                chk("stream_no_bypass", 32'(m_if.tvalid), 32'(0));
            end else begin
                chk("stream_valid", 32'(m_if.tvalid), 32'(1));
                chk("stream_data",  32'(m_if.tdata),  32'(100 + i - 1));
                chk("stream_level", 32'(level),       32'(1));
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("stream_last_data",  32'(m_if.tdata), 32'(107));
        chk("stream_last_level", 32'(level),      32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_end_valid", 32'(m_if.tvalid), 32'(0));
        @(posedge clk); #1;

        // ---------------- frame 1 (4x3), earlier beats leave col_cnt != 0 ----
        clear_pulse_counts();
        for (int b = 0; b < 12; b++) begin
            drive_beat(b == 0, (b % 4) == 3, 200 + b);
            if (b == 0) t0 = cyc;
        end
        idle(2);
        chk("f1_sof_count",  32'(n_sof),   32'(1));
        chk("f1_sof_cycle",  32'(sof_cyc), 32'(t0 + 2));
        chk("f1_done_count", 32'(n_done),  32'(0));
        chk("f1_width",      32'(frame_width),  32'(4));
        chk("f1_height",     32'(frame_height), 32'(0));

        // ---------------- frame 2 (4x3) ----------------
        clear_pulse_counts();
        for (int b = 0; b < 12; b++) begin
            drive_beat(b == 0, (b % 4) == 3, 300 + b);
            if (b == 0) t0 = cyc;
        end
        idle(2);
        chk("f2_done_count", 32'(n_done),   32'(1));
        chk("f2_done_cycle", 32'(done_cyc), 32'(t0 + 2));
        chk("f2_height",     32'(frame_height), 32'(3));
        chk("f2_width",      32'(frame_width),  32'(4));
        chk("f2_line_err",   32'(n_line),   32'(0));
        chk("f2_sof_err",    32'(n_sof),    32'(0));

        // ---------------- frame 3: lines of 4, 5, 4 ----------------
        clear_pulse_counts();
        lens = '{4, 5, 4};
        for (int ln = 0; ln < 3; ln++) begin
            for (int p = 0; p < lens[ln]; p++) begin
                drive_beat((ln == 0) && (p == 0), p == lens[ln] - 1, 400 + p);
                if ((ln == 1) && (p == lens[ln] - 1)) t_err = cyc;
            end
        end
        idle(2);
        chk("f3_line_err_count", 32'(n_line),   32'(1));
        chk("f3_line_err_cycle", 32'(line_cyc), 32'(t_err + 2));
        chk("f3_done_count",     32'(n_done),   32'(1));
        chk("f3_height",         32'(frame_height), 32'(3));
        chk("f3_width",          32'(frame_width),  32'(4));
        chk("f3_sof_err",        32'(n_sof),    32'(0));

        // ---------------- frame 4: tuser on 3rd pixel of line 2 ----------
        clear_pulse_counts();
        drive_beat(1'b1, 1'b0, 500);
        drive_beat(1'b0, 1'b0, 501);
        drive_beat(1'b0, 1'b0, 502);
        drive_beat(1'b0, 1'b1, 503);
        drive_beat(1'b0, 1'b0, 504);
        drive_beat(1'b0, 1'b0, 505);
        drive_beat(1'b1, 1'b0, 506);
        t0 = cyc;
        drive_beat(1'b0, 1'b0, 507);
        drive_beat(1'b0, 1'b1, 508);
        idle(2);
        chk("f4_sof_count",  32'(n_sof),    32'(1));
        chk("f4_sof_cycle",  32'(sof_cyc),  32'(t0 + 2));
        chk("f4_done_count", 32'(n_done),   32'(2));
        chk("f4_done_cycle", 32'(done_cyc), 32'(t0 + 2));
        chk("f4_height",     32'(frame_height), 32'(1));
        chk("f4_new_width",  32'(frame_width),  32'(3));
        chk("f4_line_err",   32'(n_line),   32'(0));

        // ---------------- reset with level = 7 ----------------
        m_if.tready = 1'b0;
        for (int i = 0; i < 7; i++) drive_beat(1'b0, 1'b0, 600 + i);
        @(negedge clk);
        chk("pre_rst_level", 32'(level), 32'(7));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_level",   32'(level),       32'(0));
        chk("async_rst_m_valid", 32'(m_if.tvalid), 32'(0));
        chk("async_rst_s_ready", 32'(s_if.tready), 32'(0));
        chk("async_rst_width",   32'(frame_width), 32'(0));
        chk("async_rst_height",  32'(frame_height), 32'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rerel_s_ready_before_edge", 32'(s_if.tready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rerel_s_ready",  32'(s_if.tready), 32'(1));
        chk("rerel_level",    32'(level),       32'(0));
        chk("rerel_m_valid",  32'(m_if.tvalid), 32'(0));
        chk("rerel_width",    32'(frame_width), 32'(0));
        chk("rerel_height",   32'(frame_height), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_video_fifo_mon
`default_nettype wire
